// File: rtl/tt_char_pkg.sv
// -----------------------------------------------------------------------------
// tt_char_pkg
// Shared types, default parameters and helper functions for the truth-table
// characterizer.
//   state_e     : characterizer FSM states
//   N_IN_DEF    : default number of gate inputs
//   SETTLE_CYC_DEF : default settle interval in cycles
//   tt_width()  : truth-table width (2**n_in) for a given input count
//   popcount()  : number of set bits in a word of up to TT_W_MAX bits
// -----------------------------------------------------------------------------
package tt_char_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEF       = 4;
    localparam int SETTLE_CYC_DEF = 3;

    // popcount() covers gates of up to 6 inputs (64-entry truth tables).
    localparam int TT_W_MAX = 64;
    localparam int PC_W     = 7;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [TT_W_MAX-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < TT_W_MAX; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tt_char_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_char_settle_timer
// Loadable down-counter that times how long each stimulus is held before the
// gate output is sampled. Stops at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : reload value
//   dec        : decrement by one when non-zero
//   zero       : count is zero
// -----------------------------------------------------------------------------
module tt_char_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/tt_characterizer.sv
// -----------------------------------------------------------------------------
// tt_characterizer
// Sweeps every input combination into a combinational gate, waits a settle
// interval, samples the gate output and assembles its truth table. The result
// is compared with an expected table captured at start.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a run (accepted only in IDLE)
//   tt_expect    : expected truth table, captured when start is accepted
//   stim_out     : gate input vector (bit k drives gate input k)
//   resp_in      : gate output under test
//   busy         : run in progress, through the done cycle
//   done         : one-cycle pulse, results valid
//   tt_out       : captured truth table, bit i = response to stimulus i
//   match        : tt_out equals the captured expected table
//   mismatch_cnt : number of differing truth-table bits
// Build option: define TT_CHAR_RESP_SYNC_EN to pass resp_in through a 2-flop
// synchronizer; the drive interval then grows by 2 cycles to cover it.
// -----------------------------------------------------------------------------
module tt_characterizer
    import tt_char_pkg::*;
#(
    parameter  int N_IN       = N_IN_DEF,
    parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
    localparam int TT_W       = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TT_W-1:0] tt_expect,
    output logic [N_IN-1:0] stim_out,
    input  logic            resp_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_out,
    output logic            match,
    output logic [N_IN:0]   mismatch_cnt
);

    logic resp_sample;

`ifdef TT_CHAR_RESP_SYNC_EN
    localparam int DRIVE_CYC = SETTLE_CYC + 2;

    logic resp_meta_q, resp_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_meta_q <= 1'b0;
            resp_sync_q <= 1'b0;
        end else begin
            resp_meta_q <= resp_in;
            resp_sync_q <= resp_meta_q;
        end
    end

    assign resp_sample = resp_sync_q;
`else
    localparam int DRIVE_CYC = SETTLE_CYC;

    assign resp_sample = resp_in;
`endif

    // The timer counts DRIVE_CYC-1 down to 0, so DRIVE lasts DRIVE_CYC cycles.
    localparam int              CNT_W     = (DRIVE_CYC > 1) ? $clog2(DRIVE_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DRIVE_CYC - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    function automatic logic [N_IN:0] diff_count(input logic [TT_W-1:0] d);
        logic [PC_W-1:0] pc;
        pc = popcount(TT_W_MAX'(d));
        return pc[N_IN:0];
    endfunction

    state_e          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [TT_W-1:0] expect_q, expect_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            match_q, match_d;
    logic [N_IN:0]   mm_q, mm_d;

    logic timer_load, timer_dec, timer_zero;

    tt_char_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (RELOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        stim_d     = stim_q;
        expect_d   = expect_q;
        tt_d       = tt_q;
        match_d    = match_q;
        mm_d       = mm_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    expect_d   = tt_expect;
                    tt_d       = '0;
                    stim_d     = '0;
                    match_d    = 1'b0;
                    mm_d       = '0;
                    timer_load = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                timer_dec = 1'b1;
                if (timer_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[stim_q] = resp_sample;
                if (stim_q == STIM_LAST) begin
                    // Compare against the table including this final bit so
                    // the verdict is valid in the same cycle as done.
                    match_d = (tt_d == expect_q);
                    mm_d    = diff_count(tt_d ^ expect_q);
                    state_d = DONE;
                end else begin
                    stim_d     = stim_q + N_IN'(1);
                    timer_load = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DONE: begin
                stim_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stim_q   <= '0;
            expect_q <= '0;
            tt_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            mm_q     <= '0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            expect_q <= expect_d;
            tt_q     <= tt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
            mm_q     <= mm_d;
        end
    end

    assign stim_out     = stim_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tt_out       = tt_q;
    assign match        = match_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_tt_characterizer.sv
// -----------------------------------------------------------------------------
// tb_tt_characterizer
// Directed bench for tt_characterizer. A behavioural gate (lookup into
// model_tt) answers the stimulus; expected tables, counts and latencies are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tt_characterizer;

    localparam int N_IN   = 4;
    localparam int TT_W   = 16;
    localparam int SETTLE = 3;
`ifdef TT_CHAR_RESP_SYNC_EN
    localparam int HOLD = SETTLE + 3;
`else
    localparam int HOLD = SETTLE + 1;
`endif
    localparam int LAT = 1 + TT_W * HOLD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [TT_W-1:0] tt_expect;
    logic [N_IN-1:0] stim_out;
    logic            resp_in;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt_out;
    logic            match;
    logic [N_IN:0]   mismatch_cnt;

    logic [TT_W-1:0] model_tt;
    assign resp_in = model_tt[stim_out];

    int   checks = 0;
    int   errors = 0;
    int   stim_bad;
    logic hold_start;
    logic toggle_exp;

    always #5 clk = ~clk;

    tt_characterizer #(
        .N_IN       (N_IN),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tt_expect    (tt_expect),
        .stim_out     (stim_out),
        .resp_in      (resp_in),
        .busy         (busy),
        .done         (done),
        .tt_out       (tt_out),
        .match        (match),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Call right after the accepting edge. Returns the cycle (1 = first cycle
    // after acceptance) in which done is seen, or -1 if it never comes.
    // Also tallies stimulus values that differ from the ascending schedule.
    task automatic wait_done(output int cyc);
        cyc      = -1;
        stim_bad = 0;
        for (int n = 1; n <= LAT + 20; n++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (toggle_exp && n == 20) tt_expect = ~tt_expect;
            if (n <= TT_W * HOLD && stim_out !== 4'((n - 1) / HOLD)) stim_bad++;
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_one(input logic [TT_W-1:0] model, input logic [TT_W-1:0] exp,
                           output int cyc);
        @(negedge clk);
        model_tt  = model;
        tt_expect = exp;
        start     = 1'b1;
        @(posedge clk);
        wait_done(cyc);
    endtask

    initial begin
        int   cyc;
        int   dones;
        logic found;

        rst_n      = 1'b0;
        start      = 1'b0;
        tt_expect  = '0;
        model_tt   = '0;
        hold_start = 1'b0;
        toggle_exp = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stim", 32'(stim_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_tt_out", 32'(tt_out), 0);
        check("rst_match", 32'(match), 0);
        check("rst_mm", 32'(mismatch_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Matching run
        run_one(16'h3A17, 16'h3A17, cyc);
        check("t2_latency", 32'(cyc), 32'(LAT));
        check("t2_tt_out", 32'(tt_out), 32'h3A17);
        check("t2_match", 32'(match), 1);
        check("t2_mm", 32'(mismatch_cnt), 0);
        check("t2_busy_in_done", 32'(busy), 1);
        check("t2_stim_sched", 32'(stim_bad), 0);
        @(negedge clk);
        check("t2_done_pulse", 32'(done), 0);
        check("t2_idle_busy", 32'(busy), 0);
        check("t2_stim_back0", 32'(stim_out), 0);
        check("t2_tt_held", 32'(tt_out), 32'h3A17);
        check("t2_match_held", 32'(match), 1);

        // One-bit expectation error
        run_one(16'h3A17, 16'h3A16, cyc);
        check("t3_latency", 32'(cyc), 32'(LAT));
        check("t3_tt_out", 32'(tt_out), 32'h3A17);
        check("t3_match", 32'(match), 0);
        check("t3_mm", 32'(mismatch_cnt), 1);

        // Constant-1 gate against all-zero expectation
        run_one(16'hFFFF, 16'h0000, cyc);
        check("t4_tt_out", 32'(tt_out), 32'hFFFF);
        check("t4_mm", 32'(mismatch_cnt), 16);
        check("t4_match", 32'(match), 0);

        // Asynchronous reset mid-cycle clears held results
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_tt_out", 32'(tt_out), 0);
        check("async_mm", 32'(mismatch_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start held for the whole run, expectation toggled mid-run
        @(negedge clk);
        model_tt   = 16'h3A17;
        tt_expect  = 16'h3A17;
        start      = 1'b1;
        hold_start = 1'b1;
        toggle_exp = 1'b1;
        @(posedge clk);
        wait_done(cyc);
        toggle_exp = 1'b0;
        check("t5_latency", 32'(cyc), 32'(LAT));
        check("t5_match", 32'(match), 1);
        check("t5_mm", 32'(mismatch_cnt), 0);
        @(negedge clk);
        check("t5_single_done", 32'(done), 0);
        check("t5_idle_gap", 32'(busy), 0);
        hold_start = 1'b0;
        @(posedge clk);
        #1;
        check("t5_run2_busy", 32'(busy), 1);
        wait_done(cyc);
        // Run 2 captured the toggled expectation ~0x3A17 = 0xC5E8.
        check("t5_run2_latency", 32'(cyc), 32'(LAT));
        check("t5_run2_tt", 32'(tt_out), 32'h3A17);
        check("t5_run2_match", 32'(match), 0);
        check("t5_run2_mm", 32'(mismatch_cnt), 16);

        // Reset while stim_out == 7, then a clean rerun
        @(negedge clk);
        model_tt  = 16'h3A17;
        tt_expect = 16'h3A17;
        start     = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (stim_out === 4'd7) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("t6_reach_stim7", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check("t6_abort_stim", 32'(stim_out), 0);
        check("t6_abort_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("t6_no_spurious_done", 32'(dones), 0);
        run_one(16'h3A17, 16'h3A17, cyc);
        check("t6_latency", 32'(cyc), 32'(LAT));
        check("t6_tt_out", 32'(tt_out), 32'h3A17);
        check("t6_match", 32'(match), 1);
        check("t6_mm", 32'(mismatch_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_characterizer.md
Name: tt_characterizer

Overview:
- Sequential truth-table reader for the small combinational gate netlists in the ABC/yosys design set.
- Sweeps every input combination into a gate-under-test, waits a settle interval, samples the gate output, and assembles the 2^N_IN-bit truth-table word, e.g. 0x3A17.
- Compares the captured word against an expected word and reports a match flag and a mismatch count.
- Sits between a synthesized gate and the design-verification harness; it is the read-back counterpart of the truth-table-to-gates flow.

Parameters:
- N_IN, 4, number of gate inputs; TT_W = 2**N_IN is a derived localparam.
- SETTLE_CYC, 3, cycles each stimulus is held before sampling; minimum 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a characterization run; accepted only in IDLE
- tt_expect  input  TT_W  expected truth table; registered when start is accepted
- stim_out  output  N_IN  stimulus to the gate inputs; stim_out[k] drives gate input k
- resp_in  input  1  gate output under test
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse when results are valid
- tt_out  output  TT_W  captured truth table; bit i = resp_in sampled while stim_out==i
- match  output  1  tt_out == registered expect; valid from done, held until next accepted start
- mismatch_cnt  output  N_IN+1  popcount(tt_out XOR expect); same validity as match

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; stim_out=0, busy=0, done=0, tt_out=0, match=0, mismatch_cnt=0; settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 at an edge → registers tt_expect, clears tt_out, sets stim_out=0, loads the settle counter with SETTLE_CYC-1, enters DRIVE.
- DRIVE: stim_out held; counter decrements each cycle; at 0 → SAMPLE. DRIVE lasts exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle): tt_out[stim_out] <= resp_in.
  - stim_out == TT_W-1 → DONE.
  - otherwise stim_out++, counter reloads, → DRIVE.
- DONE (1 cycle): done=1, busy=1; match and mismatch_cnt are registered from the final tt_out on entry so they are valid the same cycle as done. Next state is IDLE. stim_out returns to 0 on exit.
- Latency: if start is accepted at edge 0, done is high in cycle 1+TT_W*(SETTLE_CYC+1). Defaults give cycle 65.
- Each stimulus value is held SETTLE_CYC+1 cycles. Values run in ascending order 0..TT_W-1 with no wrap or repeat.
- start while busy is ignored and has no effect on the run. tt_expect changes mid-run are ignored.
- start high in the DONE cycle is ignored; it is accepted in IDLE on the following cycle if still high.
- tt_out, match and mismatch_cnt hold their values in IDLE until the next accepted start.
- Reset mid-run aborts immediately to reset values; no done pulse is produced.
- mismatch_cnt range is 0..TT_W, so width is N_IN+1: 16 fits in 5 bits.

Optional Feature:
- Macro: TT_CHAR_RESP_SYNC_EN.
- Defined: resp_in passes through a 2-flop synchronizer (reset to 0) before sampling, and DRIVE is lengthened by 2 cycles to SETTLE_CYC+2. Latency becomes 1+TT_W*(SETTLE_CYC+3), i.e. 97 cycles at defaults.
- Undefined: resp_in is sampled directly and latency is as stated in Behaviour.

Decomposition:
- Package tt_char_pkg holds:
  - state enum {IDLE, DRIVE, SAMPLE, DONE}
  - default N_IN / SETTLE_CYC constants
  - a function returning TT_W from N_IN
  - a popcount function sized for TT_W
- One natural sub-module, tt_char_settle_timer: loadable down-counter with a zero flag, reused for the DRIVE interval.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously. Release → IDLE, busy=0.
- Gate model of 0x3A17, tt_expect=0x3A17, pulse start → done in cycle 65, tt_out=0x3A17, match=1, mismatch_cnt=0.
- Same model, tt_expect=0x3A16 → tt_out=0x3A17, match=0, mismatch_cnt=1. Constant-1 model with tt_expect=0x0000 → tt_out=0xFFFF, mismatch_cnt=16.
- Monitor stim_out across one run → values 0..15 ascending, each held exactly 4 cycles, then 0 after done.
- Hold start high for the whole run and toggle tt_expect mid-run → exactly one done. Result uses the expect value captured at start. Run 2 begins the cycle after return to IDLE.
- Assert reset while stim_out==7, release, restart with model 0x3A17 → no spurious done, clean 0x3A17 result.
- With TT_CHAR_RESP_SYNC_EN defined, same stimulus as test 2 → done in cycle 97, tt_out=0x3A17.
